// File: rtl/seg7_scan_driver_if.sv
// Display-side bus of the seven-segment scan driver: BCD load strobe in, segment/digit drive out.
// The blink_mask field exists only when SEG7_SCAN_BLINK_EN is defined.
interface seg7_scan_driver_if;
  logic [23:0] bcd_in;
  logic        upd;
  logic [0:6]  seg;
  logic [5:0]  dig_sel;
  logic        frame_tick;
`ifdef SEG7_SCAN_BLINK_EN
  logic [5:0]  blink_mask;
`endif

  modport master (
`ifdef SEG7_SCAN_BLINK_EN
    output blink_mask,
`endif
    output bcd_in, upd,
    input  seg, dig_sel, frame_tick
  );

  modport slave (
`ifdef SEG7_SCAN_BLINK_EN
    input  blink_mask,
`endif
    input  bcd_in, upd,
    output seg, dig_sel, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed seven-segment driver with per-slot anti-ghost blanking and frame-synchronous
// display updates. Optional digit blinking is compiled in with macro SEG7_SCAN_BLINK_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 16
) (
  input logic               clk,
  input logic               clr,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [23:0]      shadow;
  logic [23:0]      disp;
  logic             pending;
  logic             frame_end;
  logic             in_blank;
  logic             dark;
  logic [3:0]       digit;
  logic [0:6]       seg_p1;
  logic [5:0]       dig_sel_p1;

  function automatic logic [0:6] decode(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  generate
    if (SCAN_DIV < BLANK_CYC + 2 || BLANK_CYC < 0 || BLINK_DIV < 1) begin : gen_bad_params
      $error("seg7_scan_driver: illegal SCAN_DIV/BLANK_CYC/BLINK_DIV combination");
    end
    if (BLANK_CYC == 0) begin : gen_no_blank
      assign in_blank = 1'b0;
    end else begin : gen_blank
      assign in_blank = (cnt < CNT_W'(BLANK_CYC));
    end
  endgenerate

  assign frame_end = (cnt == CNT_LAST) && (idx == 3'd5);

  always_comb begin
    digit = disp[3:0];
    case (idx)
      3'd1:    digit = disp[7:4];
      3'd2:    digit = disp[11:8];
      3'd3:    digit = disp[15:12];
      3'd4:    digit = disp[19:16];
      3'd5:    digit = disp[23:20];
      default: digit = disp[3:0];
    endcase
  end

`ifdef SEG7_SCAN_BLINK_EN
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  logic [BL_W-1:0] blink_cnt;
  logic            blink_phase;

  // Blink phase flips every BLINK_DIV frames, starting visible.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign dark = blink_phase & bus.blink_mask[idx];
`else
  assign dark = 1'b0;
`endif

  // Stage p0: scan position and frame-synchronous display register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt     <= '0;
      idx     <= 3'd0;
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A strobe landing on the frame end bypasses the shadow so it is never a frame late.
      if (frame_end) begin
        if (bus.upd) begin
          disp   <= bus.bcd_in;
          shadow <= bus.bcd_in;
        end else if (pending) begin
          disp <= shadow;
        end
        pending <= 1'b0;
      end else if (bus.upd) begin
        shadow  <= bus.bcd_in;
        pending <= 1'b1;
      end
    end
  end

  // Stage p1: registered segment and digit drive, one cycle behind the scan position.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_p1     <= '0;
      dig_sel_p1 <= '0;
    end else if (in_blank) begin
      seg_p1     <= '0;
      dig_sel_p1 <= '0;
    end else begin
      seg_p1     <= dark ? 7'b0000000 : decode(digit);
      dig_sel_p1 <= 6'd1 << idx;
    end
  end

  assign bus.seg        = seg_p1;
  assign bus.dig_sel    = dig_sel_p1;
  assign bus.frame_tick = frame_end;

endmodule
